dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Data-side responder to the pipeline's datapath/cache interface: serves dmemREN/dmemWEN/datomic requests and returns dhit/dmemload.
- Direct-mapped, write-back, write-allocate cache with an LL/SC link register.
- Fronts the memory/cache-control side (dREN/dWEN/daddr/dstore, dwait/dload).
- On halt, flushes dirty lines, writes the net hit count to memory, then raises flushed.

Parameters:
- SETS, 16, number of one-word lines (power of 2); index = dmemaddr[IDX+1:2], tag = dmemaddr[31:IDX+2], IDX = log2(SETS).
- HITCNT_ADDR, 32'h00003100, memory address that receives the hit counter after flush.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- halt  in  1  datapath halted; sticky high once asserted.
- dmemREN  in  1  datapath read request (LW, LL).
- dmemWEN  in  1  datapath write request (SW, SC).
- datomic  in  1  qualifies the request as LL (with REN) or SC (with WEN).
- dmemaddr  in  32  word address; [1:0] ignored.
- dmemstore  in  32  write data.
- dhit  out  1  request complete this cycle.
- dmemload  out  32  read data; SC result (1 success / 0 fail) on SC dhit.
- dREN  out  1  memory read.
- dWEN  out  1  memory write.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dwait  in  1  memory busy; transfer completes on a cycle with dREN|dWEN high and dwait low.
- dload  in  32  memory read data, valid when dwait low.
- flushed  out  1  flush and hit-count write complete; sticky until reset.

Behaviour:
- Reset (nRST low at edge):
  - All lines invalid and clean; link invalid; hitcnt = 0; state IDLE; flushed = 0.
  - dREN, dWEN, dhit = 0; daddr, dstore, dmemload = 0.
  - Applies mid-transaction: any in-flight memory access is abandoned. dREN/dWEN are low in the cycle after the reset edge.
- States: IDLE, WB, FETCH, FLUSH, CNT, DONE.
- IDLE with halt = 1: go to FLUSH with flush index = 0. This has priority over any request; no dhit is given.
- IDLE hit (valid, tag match, REN or WEN, and not a failed SC):
  - dhit = 1 combinationally in the same cycle; dmemload = line data.
  - Write hit: data <= dmemstore and dirty <= 1 at the edge.
  - hitcnt += 1.
- Failed SC (WEN & datomic, and link invalid or link address != dmemaddr[31:2]):
  - dhit = 1 in the same cycle with dmemload = 0.
  - No cache or memory access; hitcnt unchanged.
- Successful SC: handled as SW (hit or miss path). dmemload = 1 on its dhit. Link cleared.
- LL: handled as LW. On its dhit, link <= {1, dmemaddr[31:2]}.
- Any completed SW or successful SC whose address matches the link address clears the link.
- IDLE miss:
  - hitcnt -= 1 once.
  - Victim valid & dirty -> WB; otherwise -> FETCH.
  - Net effect: a miss followed by its hit leaves hitcnt unchanged.
- WB: dWEN = 1; daddr = {victim tag, index, 2'b00}; dstore = victim data. Hold until dwait = 0, then go to FETCH.
- FETCH: dREN = 1; daddr = {dmemaddr[31:2], 2'b00}. On dwait = 0: line <= dload, tag written, valid = 1, dirty = 0; go to IDLE.
  - The datapath holds its request, so the next cycle is a hit (a write merges then).
- dhit is never asserted outside IDLE. A request held across multiple dhit cycles is counted once per dhit cycle.
- FLUSH: examine the line at the flush index.
  - Valid & dirty: dWEN = 1 with line address/data; on dwait = 0 clear dirty and advance the index.
  - Clean or invalid: advance the index in one cycle.
  - After index SETS-1 completes, go to CNT.
- CNT: dWEN = 1, daddr = HITCNT_ADDR, dstore = hitcnt. On dwait = 0 go to DONE.
- DONE: flushed = 1; no memory requests; stays until reset.
- hitcnt is 32-bit two's complement and wraps silently.
- Requests with both REN and WEN high are illegal; WEN takes precedence.
- dREN and dWEN are never high together.

Test Plan:
- Reset, then LW 0x40 with memory word = 0xDEADBEEF, dwait low for 2 cycles -> one FETCH (dREN, daddr = 0x40), then a dhit with dmemload = 0xDEADBEEF; hitcnt = 0.
- SW 0x40 = 0x11, then SW 0x440 (same index, other tag) -> WB dWEN, daddr = 0x40, dstore = 0x11; then FETCH 0x440; then dhit.
- LL 0x80, SC 0x80 = 5 -> SC dhit with dmemload = 1, line holds 5. A second SC 0x80 -> same-cycle dhit, dmemload = 0, no dWEN.
- LL 0x80, SW 0x80 = 7, SC 0x80 = 9 -> SC fails (dmemload = 0), line = 7.
- Three LW hits plus one miss, then halt with 2 dirty lines -> exactly 2 dirty writebacks in index order, then dWEN to 0x3100 with dstore = 3; flushed = 1 sticky.
- Assert nRST low during WB with dwait high -> next cycle dREN = dWEN = 0; all lines invalid, and a previously cached address misses.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with an LL/SC link register.
// On halt it flushes dirty lines, then writes the net hit count to HITCNT_ADDR.
module dcache_responder #(
    parameter int unsigned SETS        = 16,
    parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        flushed
);
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = 30 - IDX;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WB    = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] CNT   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [SETS-1:0] valid_q, dirty_q;
    logic [TAGW-1:0] tag_q [SETS];
    logic [31:0]     data_q [SETS];
    logic [IDX-1:0]  fidx_q;
    logic [31:0]     hitcnt_q;
    logic            link_valid_q;
    logic [29:0]     link_addr_q;

    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic            is_wr, is_rd, req, sc, sc_fail, link_match, line_hit;
    logic            idle_req, hit, miss, fail_ack, flush_dirty;
    logic            unused_addr_bits;

    assign idx              = dmemaddr[IDX+1:2];
    assign tag              = dmemaddr[31:IDX+2];
    assign unused_addr_bits = ^dmemaddr[1:0];

    // WEN wins when both request strobes are high.
    assign is_wr       = dmemWEN;
    assign is_rd       = dmemREN & ~dmemWEN;
    assign req         = is_wr | is_rd;
    assign sc          = is_wr & datomic;
    assign link_match  = link_valid_q && (link_addr_q == dmemaddr[31:2]);
    assign sc_fail     = sc & ~link_match;
    assign line_hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign idle_req    = (state_q == IDLE) && !halt && req;
    assign hit         = idle_req && !sc_fail && line_hit;
    assign miss        = idle_req && !sc_fail && !line_hit;
    assign fail_ack    = idle_req && sc_fail;
    assign flush_dirty = valid_q[fidx_q] & dirty_q[fidx_q];
    assign flushed     = (state_q == DONE);

    always_comb begin
        dhit     = hit | fail_ack;
        dmemload = 32'd0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = 32'd0;
        dstore   = 32'd0;
        if (hit) begin
            dmemload = sc ? 32'd1 : data_q[idx];
        end
        case (state_q)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[idx], idx, 2'b00};
                dstore = data_q[idx];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:2], 2'b00};
            end
            FLUSH: begin
                if (flush_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
                    dstore = data_q[fidx_q];
                end
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = HITCNT_ADDR;
                dstore = hitcnt_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                end else if (miss) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FETCH;
                end
            end
            WB:    if (!dwait) state_d = FETCH;
            FETCH: if (!dwait) state_d = IDLE;
            FLUSH: begin
                if ((!flush_dirty || !dwait) && (fidx_q == IDX'(SETS - 1))) begin
                    state_d = CNT;
                end
            end
            CNT:   if (!dwait) state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            fidx_q       <= '0;
            hitcnt_q     <= 32'd0;
            link_valid_q <= 1'b0;
            link_addr_q  <= 30'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && halt) begin
                fidx_q <= '0;
            end
            // A miss pre-decrements so the hit that follows its fill nets to zero.
            if (hit) begin
                hitcnt_q <= hitcnt_q + 32'd1;
            end else if (miss) begin
                hitcnt_q <= hitcnt_q - 32'd1;
            end
            if (hit && is_wr) begin
                data_q[idx]  <= dmemstore;
                dirty_q[idx] <= 1'b1;
            end
            if (state_q == FETCH && !dwait) begin
                data_q[idx]  <= dload;
                tag_q[idx]   <= tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (state_q == FLUSH) begin
                if (flush_dirty && !dwait) begin
                    dirty_q[fidx_q] <= 1'b0;
                end
                if (!flush_dirty || !dwait) begin
                    fidx_q <= fidx_q + IDX'(1);
                end
            end
            if (hit && is_rd && datomic) begin
                link_valid_q <= 1'b1;
                link_addr_q  <= dmemaddr[31:2];
            end else if (hit && is_wr && link_match) begin
                link_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: table of requests with expected load data and
// latency, plus hand-written flush and mid-transaction reset sequences.
module tb_dcache_responder;
    logic        CLK = 1'b0;
    logic        nRST, halt, dmemREN, dmemWEN, datomic;
    logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;
    logic        dhit, dREN, dWEN, dwait, flushed;

    dcache_responder dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .flushed(flushed)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Memory model: one wait cycle per access unless stalled.
    logic [31:0] mem [0:4095];
    int          wcnt = 0;
    logic        stall = 1'b0;
    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} xact_t;
    xact_t log_q[$];

    assign dwait = stall || (wcnt < 1);
    assign dload = mem[daddr[13:2]];

    always @(posedge CLK) begin
        if ((dREN || dWEN) && !dwait) begin
            wcnt <= 0;
            if (dWEN) mem[daddr[13:2]] <= dstore;
            log_q.push_back({dWEN, daddr, dWEN ? dstore : dload});
        end else if (dREN || dWEN) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge CLK) begin
        checks++;
        if (dREN && dWEN) begin
            failures++;
            $display("FAIL dren_dwen_exclusive: both high at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_x(input string name, input xact_t act, input xact_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                     name, act.we, act.addr, act.data, exp.we, exp.addr, exp.data);
        end
    endtask

    // Called just after a negedge; holds the request until dhit, then releases it.
    task automatic do_req(input logic ren, input logic wen, input logic at,
                          input logic [31:0] a, input logic [31:0] s,
                          output logic [31:0] load, output int cyc);
        logic ok;
        dmemREN = ren; dmemWEN = wen; datomic = at; dmemaddr = a; dmemstore = s;
        cyc = 0; ok = 1'b0; load = 32'hx;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (dhit) begin
                load = dmemload;
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
            cyc++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: addr %h got no dhit expected dhit", a);
        end
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    typedef struct {
        logic ren, wen, at;
        logic [31:0] addr, store;
        logic chk_load;
        logic [31:0] exp_load;
        int exp_cyc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic ren, input logic wen, input logic at, input logic [31:0] a,
                       input logic [31:0] s, input logic cl, input logic [31:0] el,
                       input int ec);
        vec_t v;
        v.ren = ren; v.wen = wen; v.at = at; v.addr = a; v.store = s;
        v.chk_load = cl; v.exp_load = el; v.exp_cyc = ec;
        vecs.push_back(v);
    endtask

    logic [31:0] ld;
    int          cyc, nlog;
    xact_t       exp_log[$];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[12'h010] = 32'hDEAD_BEEF;
        mem[12'h110] = 32'h0000_0022;
        halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
        dmemaddr = 32'd0; dmemstore = 32'd0;
        @(negedge CLK);
        do_reset();
        #1;
        check("reset_dren", {31'd0, dREN}, 32'd0);
        check("reset_dwen", {31'd0, dWEN}, 32'd0);
        check("reset_dhit", {31'd0, dhit}, 32'd0);
        check("reset_daddr", daddr, 32'd0);
        check("reset_flushed", {31'd0, flushed}, 32'd0);
        @(negedge CLK);

        // ren wen at addr store chk_load exp_load cycles (clean miss 3, dirty miss 5)
        add(1, 0, 0, 32'h040, 0,     1, 32'hDEAD_BEEF, 3);
        add(0, 1, 0, 32'h040, 32'h11, 0, 0, 0);
        add(0, 1, 0, 32'h440, 32'h33, 0, 0, 5);
        add(1, 0, 0, 32'h440, 0,     1, 32'h33, 0);
        add(1, 0, 0, 32'h040, 0,     1, 32'h11, 5);
        add(1, 0, 1, 32'h080, 0,     1, 32'h0, 3);
        add(0, 1, 1, 32'h080, 5,     1, 32'h1, 0);
        add(1, 0, 0, 32'h080, 0,     1, 32'h5, 0);
        add(0, 1, 1, 32'h080, 6,     1, 32'h0, 0);
        add(1, 0, 0, 32'h080, 0,     1, 32'h5, 0);
        add(1, 0, 1, 32'h080, 0,     1, 32'h5, 0);
        add(0, 1, 0, 32'h080, 7,     0, 0, 0);
        add(0, 1, 1, 32'h080, 9,     1, 32'h0, 0);
        add(1, 0, 0, 32'h080, 0,     1, 32'h7, 0);
        add(1, 0, 1, 32'h080, 0,     1, 32'h7, 0);
        add(0, 1, 1, 32'h0C0, 1,     1, 32'h0, 0);
        add(0, 1, 1, 32'h080, 8,     1, 32'h1, 0);
        add(1, 0, 0, 32'h080, 0,     1, 32'h8, 0);
        add(1, 0, 1, 32'h100, 0,     1, 32'h0, 5);
        add(1, 0, 0, 32'h500, 0,     1, 32'h0, 3);
        add(0, 1, 1, 32'h100, 4,     1, 32'h1, 3);
        add(1, 0, 0, 32'h100, 0,     1, 32'h4, 0);
        add(1, 0, 0, 32'h080, 0,     1, 32'h8, 5);
        add(0, 1, 1, 32'h080, 3,     1, 32'h0, 0);

        foreach (vecs[i]) begin
            nlog = log_q.size();
            do_req(vecs[i].ren, vecs[i].wen, vecs[i].at, vecs[i].addr, vecs[i].store, ld, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            if (vecs[i].chk_load) check($sformatf("vec%0d_load", i), ld, vecs[i].exp_load);
            // A failed SC must not touch memory.
            if (vecs[i].at && vecs[i].wen && vecs[i].exp_load == 0)
                check($sformatf("vec%0d_sc_fail_nomem", i), log_q.size(), nlog);
        end

        exp_log = '{'{1'b0, 32'h040, 32'hDEAD_BEEF}, '{1'b1, 32'h040, 32'h11},
                    '{1'b0, 32'h440, 32'h22},       '{1'b1, 32'h440, 32'h33},
                    '{1'b0, 32'h040, 32'h11},       '{1'b0, 32'h080, 32'h0},
                    '{1'b1, 32'h080, 32'h8},        '{1'b0, 32'h100, 32'h0},
                    '{1'b0, 32'h500, 32'h0},        '{1'b0, 32'h100, 32'h0},
                    '{1'b1, 32'h100, 32'h4},        '{1'b0, 32'h080, 32'h8}};
        check("table_log_size", log_q.size(), exp_log.size());
        foreach (exp_log[i])
            if (i < log_q.size()) check_x($sformatf("table_log%0d", i), log_q[i], exp_log[i]);

        // Flush: two dirty lines, hit count 3.
        do_reset();
        @(negedge CLK);
        do_req(0, 1, 0, 32'h010, 32'hA1, ld, cyc);
        do_req(0, 1, 0, 32'h020, 32'hB2, ld, cyc);
        do_req(1, 0, 0, 32'h030, 0, ld, cyc);
        check("flush_setup_miss_cycles", cyc, 3);
        repeat (3) begin
            do_req(1, 0, 0, 32'h010, 0, ld, cyc);
            check("flush_setup_hit_load", ld, 32'hA1);
        end
        log_q.delete();
        halt = 1'b1;
        dmemREN = 1'b1; dmemaddr = 32'h010;
        #1;
        check("halt_priority_nohit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        dmemREN = 1'b0;
        for (int i = 0; i < 200 && !flushed; i++) @(negedge CLK);
        check("flushed_reached", {31'd0, flushed}, 32'd1);
        exp_log = '{'{1'b1, 32'h010, 32'hA1}, '{1'b1, 32'h020, 32'hB2},
                    '{1'b1, 32'h3100, 32'h3}};
        check("flush_log_size", log_q.size(), exp_log.size());
        foreach (exp_log[i])
            if (i < log_q.size()) check_x($sformatf("flush_log%0d", i), log_q[i], exp_log[i]);
        check("hitcnt_in_mem", mem[12'hC40], 32'h3);
        repeat (5) @(negedge CLK);
        check("flushed_sticky", {31'd0, flushed}, 32'd1);
        check("done_no_mem", {30'd0, dREN, dWEN}, 32'd0);
        halt = 1'b0;

        // Reset in the middle of a stalled writeback.
        do_reset();
        @(negedge CLK);
        do_req(0, 1, 0, 32'h040, 32'h1, ld, cyc);
        check("rst_setup_cycles", cyc, 3);
        stall = 1'b1;
        dmemWEN = 1'b1; dmemaddr = 32'h440; dmemstore = 32'h2;
        @(negedge CLK);
        check("wb_dwen", {31'd0, dWEN}, 32'd1);
        check("wb_daddr", daddr, 32'h040);
        check("wb_dstore", dstore, 32'h1);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_mem_idle", {30'd0, dREN, dWEN}, 32'd0);
        check("midrst_no_hit", {31'd0, dhit}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1; stall = 1'b0; dmemWEN = 1'b0;
        @(negedge CLK);
        do_req(1, 0, 0, 32'h040, 0, ld, cyc);
        check("after_rst_miss_cycles", cyc, 3);
        check("after_rst_load", ld, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running expected finish");
        $fatal(1);
    end
endmodule
